// File: rtl/serial_word_gen_if.sv
// Load handshake and serial framing bundle for serial_word_gen.
// The master side drives the word in; the slave side is the serializer.
interface serial_word_gen_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             SOUT;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output din,
        output load_valid,
        input  load_ready,
        input  SOUT,
        input  sout_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  din,
        input  load_valid,
        output load_ready,
        output SOUT,
        output sout_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_word_gen.sv
// Parallel-to-serial source: accepts a WIDTH-bit word on a valid/ready handshake
// and shifts it out one bit per CLK on SOUT with sout_valid/done framing.
module serial_word_gen #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic            CLK,
    input  logic            reset,
    serial_word_gen_if.slave bus
);
    localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] din_rest;
    logic [WIDTH-1:0] sreg_rest;
    logic             first_bit;
    logic             next_bit;
    logic             at_last;
    logic             accept;

    assign at_last        = (state == SHIFT) && (cnt == LAST);
    assign bus.load_ready = (state == IDLE) || at_last;
    assign accept         = bus.load_valid && bus.load_ready;
    assign cnt_next       = cnt + 1'b1;

    // The bit for step 0 goes straight to SOUT at the accepting edge; the
    // shift register holds the remaining bits aligned to the outgoing end.
    always_comb begin
        first_bit = 1'b0;
        next_bit  = 1'b0;
        din_rest  = '0;
        sreg_rest = '0;
        if (MSB_FIRST) begin
            first_bit = bus.din[WIDTH-1];
            next_bit  = sreg[WIDTH-1];
            din_rest  = bus.din << 1;
            sreg_rest = sreg << 1;
        end else begin
            first_bit = bus.din[0];
            next_bit  = sreg[0];
            din_rest  = bus.din >> 1;
            sreg_rest = sreg >> 1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            sreg           <= '0;
            bus.SOUT       <= IDLE_LEVEL;
            bus.sout_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else if (accept) begin
            state          <= SHIFT;
            cnt            <= '0;
            sreg           <= din_rest;
            bus.SOUT       <= first_bit;
            bus.sout_valid <= 1'b1;
            bus.busy       <= 1'b1;
            bus.done       <= 1'b0;
        end else if (state == SHIFT) begin
            if (at_last) begin
                state          <= IDLE;
                cnt            <= '0;
                sreg           <= '0;
                bus.SOUT       <= IDLE_LEVEL;
                bus.sout_valid <= 1'b0;
                bus.busy       <= 1'b0;
                bus.done       <= 1'b0;
            end else begin
                cnt      <= cnt_next;
                sreg     <= sreg_rest;
                bus.SOUT <= next_bit;
                // done is registered, so it is raised as cnt steps onto the last bit
                bus.done <= (cnt_next == LAST);
            end
        end
    end
endmodule
